// File: rtl/rom_angle_reader.sv
// rom_angle_reader
// Read-side sequencer for the angle-input ROM. On start it sweeps ROM
// addresses START_ADDR..LAST_ADDR. Each word is fetched in one cycle, then
// registered and offered to the CORDIC input stage on a valid/ready
// handshake. Sweeps may be one-shot or continuous (loop_en), and can be
// aborted at any time.
//
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   start          begin a sweep (only looked at in IDLE)
//   loop_en        wrap to START_ADDR after LAST_ADDR (sampled at last handshake)
//   abort          drop the sweep and return to IDLE
//   rom_address    ROM address
//   rom_read_en    ROM read enable
//   rom_ce         ROM chip enable
//   rom_data       ROM read data (combinational from the ROM)
//   ang_data       registered angle word
//   ang_index      ROM address the word came from
//   ang_valid      ang_data/ang_index valid
//   ang_ready      consumer accept
//   busy           high while fetching or holding a word
//   done           one-cycle pulse at the end of a non-looping sweep
module rom_angle_reader #(
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 32,
  parameter int START_ADDR = 0,
  parameter int LAST_ADDR  = 360
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              loop_en,
  input  logic              abort,
  output logic [ADDR_W-1:0] rom_address,
  output logic              rom_read_en,
  output logic              rom_ce,
  input  logic [DATA_W-1:0] rom_data,
  output logic [DATA_W-1:0] ang_data,
  output logic [ADDR_W-1:0] ang_index,
  output logic              ang_valid,
  input  logic              ang_ready,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W-1:0] START_A = ADDR_W'(START_ADDR);
  localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(LAST_ADDR);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [ADDR_W-1:0]   index_q, index_d;
  logic                valid_q, valid_d;

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= START_A;
      data_q  <= '0;
      index_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      index_q <= index_d;
      valid_q <= valid_d;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    index_d = index_q;
    valid_d = valid_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_FETCH;
          addr_d  = START_A;
        end
      end
      S_FETCH: begin
        if (abort) begin
          state_d = S_IDLE;
          addr_d  = START_A;
          valid_d = 1'b0;
        end else begin
          // ROM output is valid during the single FETCH cycle; capture it here.
          state_d = S_HOLD;
          data_d  = rom_data;
          index_d = addr_q;
          valid_d = 1'b1;
        end
      end
      S_HOLD: begin
        // abort wins over a handshake in the same cycle.
        if (abort) begin
          state_d = S_IDLE;
          addr_d  = START_A;
          valid_d = 1'b0;
        end else if (ang_ready) begin
          valid_d = 1'b0;
          if (addr_q != LAST_A) begin
            state_d = S_FETCH;
            addr_d  = addr_q + 1'b1;
          end else if (loop_en) begin
            state_d = S_FETCH;
            addr_d  = START_A;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        addr_d  = START_A;
      end
      default: begin
        state_d = S_IDLE;
        addr_d  = START_A;
        valid_d = 1'b0;
      end
    endcase
  end

  // Outputs: registers or state decode only
  always_comb begin
    rom_address = addr_q;
    rom_ce      = (state_q == S_FETCH);
    rom_read_en = (state_q == S_FETCH);
    busy        = (state_q == S_FETCH) || (state_q == S_HOLD);
    done        = (state_q == S_DONE);
    ang_data    = data_q;
    ang_index   = index_q;
    ang_valid   = valid_q;
  end

endmodule

// File: tb/tb_rom_angle_reader.sv
module tb_rom_angle_reader;
  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              loop_en;
  logic              abort;
  logic [ADDR_W-1:0] rom_address;
  logic              rom_read_en;
  logic              rom_ce;
  logic [DATA_W-1:0] rom_data;
  logic [DATA_W-1:0] ang_data;
  logic [ADDR_W-1:0] ang_index;
  logic              ang_valid;
  logic              ang_ready;
  logic              busy;
  logic              done;

  int checks = 0;
  int errors = 0;

  rom_angle_reader #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .START_ADDR(0), .LAST_ADDR(360)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .loop_en(loop_en), .abort(abort),
    .rom_address(rom_address), .rom_read_en(rom_read_en), .rom_ce(rom_ce),
    .rom_data(rom_data), .ang_data(ang_data), .ang_index(ang_index),
    .ang_valid(ang_valid), .ang_ready(ang_ready), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // ROM model: mem[i] = i*1000, zero when not enabled
  assign rom_data = (rom_ce && rom_read_en) ? ({22'd0, rom_address} * 32'd1000) : 32'd0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; loop_en = 1'b0; abort = 1'b0; ang_ready = 1'b1;
    step(); step();
    rst = 1'b0;
    checks++;
    if (rom_address !== 10'd0 || rom_ce !== 1'b0 || rom_read_en !== 1'b0 ||
        ang_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
        ang_data !== 32'd0 || ang_index !== 10'd0) begin
      errors++;
      $display("FAIL reset: addr=%0d ce=%b re=%b vld=%b busy=%b done=%b data=%0d idx=%0d required all zero",
               rom_address, rom_ce, rom_read_en, ang_valid, busy, done, ang_data, ang_index);
    end
  endtask

  task automatic test_single_sweep();
    int exp_idx;
    bit exp_valid;
    int bad;
    exp_idx = 0;
    bad = 0;
    ang_ready = 1'b1; loop_en = 1'b0;
    start = 1'b1;                       // cycle 0
    for (int c = 1; c <= 725; c++) begin
      step();
      if (c == 1) start = 1'b0;
      exp_valid = (c >= 2) && (c <= 722) && (c % 2 == 0);
      checks++;
      if (ang_valid !== exp_valid) begin
        errors++; bad++;
        if (bad < 10) $display("FAIL sweep_valid cycle %0d: got %b want %b", c, ang_valid, exp_valid);
      end
      if (exp_valid) begin
        checks++;
        if (ang_index !== 10'(exp_idx) || ang_data !== 32'(exp_idx * 1000)) begin
          errors++; bad++;
          if (bad < 10) $display("FAIL sweep_word cycle %0d: idx=%0d data=%0d want idx=%0d data=%0d",
                                 c, ang_index, ang_data, exp_idx, exp_idx * 1000);
        end
        exp_idx++;
      end
      if (c == 1) begin
        checks++;
        if (rom_ce !== 1'b1 || rom_read_en !== 1'b1 || rom_address !== 10'd0) begin
          errors++;
          $display("FAIL sweep_fetch0: ce=%b re=%b addr=%0d want 1 1 0", rom_ce, rom_read_en, rom_address);
        end
      end
      checks++;
      if (done !== (c == 723)) begin
        errors++; bad++;
        if (bad < 10) $display("FAIL sweep_done cycle %0d: got %b want %b", c, done, (c == 723));
      end
      checks++;
      if (busy !== (c <= 722)) begin
        errors++; bad++;
        if (bad < 10) $display("FAIL sweep_busy cycle %0d: got %b want %b", c, busy, (c <= 722));
      end
    end
    checks++;
    if (exp_idx != 361) begin
      errors++;
      $display("FAIL sweep_count: got %0d words want 361", exp_idx);
    end
  endtask

  task automatic test_backpressure();
    int prev;
    prev = -1;
    ang_ready = 1'b1; loop_en = 1'b0;
    start = 1'b1; step(); start = 1'b0;
    for (int k = 0; k < 100 && !(ang_valid && ang_index == 10'd7); k++) begin
      step();
      if (ang_valid) begin
        checks++;
        if (int'(ang_index) != prev + 1) begin
          errors++;
          $display("FAIL bp_seq: got idx %0d want %0d", ang_index, prev + 1);
        end
        prev = int'(ang_index);
      end
    end
    checks++;
    if (!(ang_valid && ang_index == 10'd7)) begin
      errors++;
      $display("FAIL bp_reach7: vld=%b idx=%0d want 1 7", ang_valid, ang_index);
    end
    ang_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      checks++;
      if (ang_valid !== 1'b1 || ang_index !== 10'd7 || ang_data !== 32'd7000 || rom_ce !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold %0d: vld=%b idx=%0d data=%0d ce=%b want 1 7 7000 0",
                 k, ang_valid, ang_index, ang_data, rom_ce);
      end
    end
    ang_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      if (ang_valid) begin
        checks++;
        if (int'(ang_index) != prev + 1 || ang_data !== 32'(int'(ang_index) * 1000)) begin
          errors++;
          $display("FAIL bp_after: idx=%0d data=%0d want idx %0d", ang_index, ang_data, prev + 1);
        end
        prev = int'(ang_index);
      end
    end
    checks++;
    if (prev != 9) begin
      errors++;
      $display("FAIL bp_progress: last idx %0d want 9", prev);
    end
    abort = 1'b1; step(); abort = 1'b0;
  endtask

  task automatic test_loop();
    int bad;
    bit seen360;
    bit wrapped;
    bad = 0; seen360 = 1'b0; wrapped = 1'b0;
    ang_ready = 1'b1; loop_en = 1'b1;
    start = 1'b1; step(); start = 1'b0;
    for (int k = 0; k < 800 && !wrapped; k++) begin
      step();
      if (done !== 1'b0 || busy !== 1'b1) begin
        bad++;
        if (bad < 5) $display("FAIL loop_flags: done=%b busy=%b want 0 1", done, busy);
      end
      if (ang_valid && seen360) wrapped = 1'b1;
      else if (ang_valid && ang_index == 10'd360) seen360 = 1'b1;
    end
    checks++;
    if (bad != 0) errors++;
    checks++;
    if (!wrapped || ang_index !== 10'd0 || ang_data !== 32'd0) begin
      errors++;
      $display("FAIL loop_wrap: wrapped=%b idx=%0d data=%0d want 1 0 0", wrapped, ang_index, ang_data);
    end
    loop_en = 1'b0;
    abort = 1'b1; step(); abort = 1'b0;
  endtask

  task automatic test_abort();
    ang_ready = 1'b1; loop_en = 1'b0;
    start = 1'b1; step(); start = 1'b0;
    for (int k = 0; k < 300 && !(ang_valid && ang_index == 10'd100); k++) step();
    checks++;
    if (!(ang_valid && ang_index == 10'd100)) begin
      errors++;
      $display("FAIL abort_reach100: vld=%b idx=%0d", ang_valid, ang_index);
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
    checks++;
    if (ang_valid !== 1'b0 || done !== 1'b0 || rom_address !== 10'd0 || busy !== 1'b0 || rom_ce !== 1'b0) begin
      errors++;
      $display("FAIL abort_idle: vld=%b done=%b addr=%0d busy=%b ce=%b want 0 0 0 0 0",
               ang_valid, done, rom_address, busy, rom_ce);
    end
    step();
    checks++;
    if (busy !== 1'b0 || ang_valid !== 1'b0) begin
      errors++;
      $display("FAIL abort_stays_idle: busy=%b vld=%b want 0 0", busy, ang_valid);
    end
    start = 1'b1; step(); start = 1'b0;
    step();
    checks++;
    if (ang_valid !== 1'b1 || ang_index !== 10'd0 || ang_data !== 32'd0) begin
      errors++;
      $display("FAIL abort_restart: vld=%b idx=%0d data=%0d want 1 0 0", ang_valid, ang_index, ang_data);
    end
    abort = 1'b1; step(); abort = 1'b0;
  endtask

  task automatic test_start_while_busy();
    ang_ready = 1'b1; loop_en = 1'b0;
    start = 1'b1; step(); start = 1'b0;
    for (int k = 0; k < 200 && !(ang_valid && ang_index == 10'd50); k++) step();
    checks++;
    if (!(ang_valid && ang_index == 10'd50)) begin
      errors++;
      $display("FAIL sb_reach50: vld=%b idx=%0d", ang_valid, ang_index);
    end
    start = 1'b1; step(); start = 1'b0;
    checks++;
    if (rom_ce !== 1'b1 || rom_address !== 10'd51) begin
      errors++;
      $display("FAIL sb_fetch: ce=%b addr=%0d want 1 51", rom_ce, rom_address);
    end
    step();
    checks++;
    if (ang_valid !== 1'b1 || ang_index !== 10'd51 || ang_data !== 32'd51000) begin
      errors++;
      $display("FAIL sb_next: vld=%b idx=%0d data=%0d want 1 51 51000", ang_valid, ang_index, ang_data);
    end
  endtask

  task automatic test_reset_midsweep();
    for (int k = 0; k < 400 && !(ang_valid && ang_index == 10'd200); k++) step();
    checks++;
    if (!(ang_valid && ang_index == 10'd200)) begin
      errors++;
      $display("FAIL rst_reach200: vld=%b idx=%0d", ang_valid, ang_index);
    end
    rst = 1'b1; step(); rst = 1'b0;
    checks++;
    if (rom_address !== 10'd0 || rom_ce !== 1'b0 || rom_read_en !== 1'b0 ||
        ang_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
        ang_data !== 32'd0 || ang_index !== 10'd0) begin
      errors++;
      $display("FAIL rst_mid: addr=%0d ce=%b re=%b vld=%b busy=%b done=%b data=%0d idx=%0d required all zero",
               rom_address, rom_ce, rom_read_en, ang_valid, busy, done, ang_data, ang_index);
    end
    step();
    checks++;
    if (busy !== 1'b0 || rom_ce !== 1'b0) begin
      errors++;
      $display("FAIL rst_idle: busy=%b ce=%b want 0 0", busy, rom_ce);
    end
  endtask

  initial begin
    test_reset();
    test_single_sweep();
    test_backpressure();
    test_loop();
    test_abort();
    test_start_while_busy();
    test_reset_midsweep();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
